// File: rtl/dtc_share_sched.sv
// Round-robin time-sharing of one combinational decision-tree classifier across NREQ requesters.
// Each grant holds the classifier input for CLS_LAT cycles, then returns the class on a valid/ready channel.
module dtc_share_sched #(
  parameter int NREQ    = 4,
  parameter int IDW     = 2,
  parameter int CLS_LAT = 2,
  parameter int CNTW    = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NREQ-1:0]    req_valid,
  input  logic [NREQ*12-1:0] req_feat,
  output logic [NREQ-1:0]    req_ready,
  output logic [11:0]        cls_inp,
  input  logic [2:0]         cls_outp,
  output logic               rsp_valid,
  output logic [IDW-1:0]     rsp_id,
  output logic [2:0]         rsp_class,
  input  logic               rsp_ready,
  output logic               busy,
  output logic [CNTW-1:0]    done_cnt
);

  typedef enum logic [1:0] {IDLE, EVAL, RESP} state_t;

  state_t         state, state_nxt;
  logic [IDW-1:0] rr_ptr, gnt_id, winner;
  logic [3:0]     wcnt;
  logic           found, accept, capture, rsp_hs;

  // Walk from the highest offset down so the lowest offset from rr_ptr wins.
  always_comb begin
    int idx;
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = NREQ-1; k >= 0; k--) begin
      idx = (int'(rr_ptr) + k) % NREQ;
      if (req_valid[idx]) begin
        found  = 1'b1;
        winner = IDW'(idx);
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state == IDLE && found) req_ready[winner] = 1'b1;
  end

  assign accept  = (state == IDLE) && found;
  assign capture = (state == EVAL) && (wcnt == 4'd0);
  assign rsp_hs  = (state == RESP) && rsp_ready;
  assign busy    = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (accept)  state_nxt = EVAL;
      EVAL:    if (capture) state_nxt = RESP;
      RESP:    if (rsp_hs)  state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr    <= '0;
      gnt_id    <= '0;
      wcnt      <= '0;
      cls_inp   <= '0;
      rsp_valid <= 1'b0;
      rsp_id    <= '0;
      rsp_class <= '0;
      done_cnt  <= '0;
    end else begin
      if (accept) begin
        cls_inp <= req_feat[int'(winner)*12 +: 12];
        gnt_id  <= winner;
        wcnt    <= 4'(CLS_LAT-1);
      end
      if (state == EVAL && wcnt != 4'd0) wcnt <= wcnt - 4'd1;
      if (capture) begin
        rsp_class <= cls_outp;
        rsp_id    <= gnt_id;
        rsp_valid <= 1'b1;
      end
      // Pointer advances only on completion so an aborted grant does not skip a requester.
      if (rsp_hs) begin
        rsp_valid <= 1'b0;
        done_cnt  <= done_cnt + 1'b1;
        rr_ptr    <= (int'(gnt_id) == NREQ-1) ? '0 : gnt_id + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_dtc_share_sched.sv
// Scoreboard bench for dtc_share_sched with a stub classifier; small counter width exercises wrap.
module tb_dtc_share_sched;
  localparam int NREQ = 4, IDW = 2, CLS_LAT = 2, CNTW = 4;

  logic               clk = 1'b0, rst_n = 1'b0;
  logic [NREQ-1:0]    req_valid = '0;
  logic [NREQ*12-1:0] req_feat = '0;
  logic [NREQ-1:0]    req_ready;
  logic [11:0]        cls_inp;
  logic [2:0]         cls_outp;
  logic               rsp_valid, rsp_ready = 1'b0, busy;
  logic [IDW-1:0]     rsp_id;
  logic [2:0]         rsp_class;
  logic [CNTW-1:0]    done_cnt;

  dtc_share_sched #(.NREQ(NREQ), .IDW(IDW), .CLS_LAT(CLS_LAT), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_feat(req_feat),
    .req_ready(req_ready), .cls_inp(cls_inp), .cls_outp(cls_outp),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_class(rsp_class),
    .rsp_ready(rsp_ready), .busy(busy), .done_cnt(done_cnt));

  always #5 clk = ~clk;

  // Stub tree: bit 11 set -> 7; else nibble [7:4] above 8 -> 6; else low three bits.
  always_comb begin
    if (cls_inp[11])              cls_outp = 3'b111;
    else if (cls_inp[7:4] > 4'h8) cls_outp = 3'b110;
    else                          cls_outp = cls_inp[2:0];
  end

  typedef struct packed { logic [IDW-1:0] id; logic [2:0] cls; } exp_t;
  exp_t sb[$];

  int checks = 0, failures = 0;
  int cyc = 0, acc_cnt = 0;
  bit chk_spacing = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) cyc++;

  // Monitor: grant shape, latency, spacing, response contents and completion count.
  int acc_cyc = 0, last_acc = 0;
  bit rv_prev = 1'b0, hs_prev = 1'b0, sp_prev = 1'b0;
  logic [CNTW-1:0] exp_done = '0;
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_done = '0; rv_prev = 1'b0; hs_prev = 1'b0; sp_prev = 1'b0;
    end else begin
      if (hs_prev) chk("done_cnt", 32'(done_cnt), 32'(exp_done));
      hs_prev = 1'b0;
      if (req_ready != '0) begin
        chk("ready_onehot", 32'($onehot(req_ready)), 32'd1);
        if (chk_spacing && sp_prev) chk("accept_spacing", 32'(cyc - last_acc), 32'(CLS_LAT+2));
        last_acc = cyc; acc_cyc = cyc; acc_cnt++;
        sp_prev = chk_spacing;
      end
      if (rsp_valid && !rv_prev) chk("rsp_latency", 32'(cyc - acc_cyc), 32'(CLS_LAT+1));
      rv_prev = rsp_valid;
      if (rsp_valid && rsp_ready) begin
        if (sb.size() == 0) begin
          failures++; checks++;
          $display("FAIL sb_underflow: got response id %0d with nothing expected", rsp_id);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("rsp_id", 32'(rsp_id), 32'(e.id));
          chk("rsp_class", 32'(rsp_class), 32'(e.cls));
        end
        exp_done = exp_done + 1'b1;
        hs_prev = 1'b1;
      end
    end
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic wait_acc(input int n);
    int t = 0;
    while (acc_cnt < n && t < 300) begin @(posedge clk); t++; end
    #1;
    if (acc_cnt < n) begin failures++; checks++; $display("FAIL wait_acc: got %0d accepts expected %0d", acc_cnt, n); end
  endtask

  task automatic wait_drain();
    int t = 0;
    while (sb.size() != 0 && t < 300) begin @(posedge clk); t++; end
    #1;
    if (sb.size() != 0) begin failures++; checks++; $display("FAIL drain: got %0d pending expected 0", sb.size()); sb.delete(); end
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    chk({tag, "_busy"},      32'(busy), 0);
    chk({tag, "_req_ready"}, 32'(req_ready), 0);
    chk({tag, "_cls_inp"},   32'(cls_inp), 0);
    chk({tag, "_rsp_id"},    32'(rsp_id), 0);
    chk({tag, "_rsp_class"}, 32'(rsp_class), 0);
    chk({tag, "_done_cnt"},  32'(done_cnt), 0);
  endtask

  initial begin
    int base;
    // Classes: 0A5 -> 6, 832 -> 7, 013 -> 3, 064 -> 4, FFF -> 7
    req_feat = {12'h064, 12'h013, 12'h832, 12'h0A5};
    #12 chk_reset_vals("por");
    step(); rst_n = 1'b1;
    step();

    // Round-robin with all valid, consumer always ready
    rsp_ready = 1'b1; chk_spacing = 1'b1;
    sb.push_back('{2'd0, 3'b110}); sb.push_back('{2'd1, 3'b111});
    sb.push_back('{2'd2, 3'b011}); sb.push_back('{2'd3, 3'b100});
    sb.push_back('{2'd0, 3'b110});
    req_valid = 4'b1111;
    wait_acc(5);
    req_valid = '0; chk_spacing = 1'b0;
    wait_drain();
    step();
    chk("rr_done", 32'(done_cnt), 5);

    // Single request (rr_ptr=1 wraps to 0) with feature change after accept
    base = acc_cnt;
    sb.push_back('{2'd0, 3'b110});
    req_valid = 4'b0001;
    @(negedge clk) chk("single_ready", 32'(req_ready), 32'b0001);
    wait_acc(base + 1);
    req_valid = '0;
    chk("single_cls_inp", 32'(cls_inp), 32'h0A5);
    chk("single_busy", 32'(busy), 1);
    step();
    req_feat[11:0] = 12'hFFF;
    step();
    chk("stable_cls_inp", 32'(cls_inp), 32'h0A5);
    wait_drain();
    step();
    chk("single_done", 32'(done_cnt), 6);
    chk("idle_cls_inp", 32'(cls_inp), 32'h0A5);

    // Backpressure on requester 2 while others request
    rsp_ready = 1'b0;
    base = acc_cnt;
    sb.push_back('{2'd2, 3'b011});
    req_valid = 4'b0100;
    wait_acc(base + 1);
    req_valid = 4'b1001;
    step(); step();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_valid", 32'(rsp_valid), 1);
      chk("bp_id", 32'(rsp_id), 2);
      chk("bp_class", 32'(rsp_class), 32'b011);
      chk("bp_ready", 32'(req_ready), 0);
      chk("bp_busy", 32'(busy), 1);
    end
    chk("bp_done_hold", 32'(done_cnt), 6);
    step();
    req_valid = 4'b1000; rsp_ready = 1'b1;
    wait_drain();
    chk("bp_done", 32'(done_cnt), 7);

    // Requester 3 accepted, then reset during EVAL
    chk("rst_pre_ready", 32'(req_ready), 32'b1000);
    step();
    req_valid = '0;
    chk("rst_pre_busy", 32'(busy), 1);
    chk("rst_pre_cls_inp", 32'(cls_inp), 32'h064);
    #2 rst_n = 1'b0;
    #1 chk_reset_vals("mid");
    step(); rst_n = 1'b1;
    base = acc_cnt;
    sb.push_back('{2'd0, 3'b111});
    req_valid = 4'b1001;
    wait_acc(base + 1);
    req_valid = '0;
    wait_drain();
    step();
    chk("post_rst_done", 32'(done_cnt), 1);

    // 16 more completions wrap the 4-bit counter back to 1
    base = acc_cnt;
    for (int r = 0; r < 4; r++) begin
      sb.push_back('{2'd1, 3'b111}); sb.push_back('{2'd2, 3'b011});
      sb.push_back('{2'd3, 3'b100}); sb.push_back('{2'd0, 3'b111});
    end
    chk_spacing = 1'b1;
    req_valid = 4'b1111;
    wait_acc(base + 16);
    req_valid = '0; chk_spacing = 1'b0;
    wait_drain();
    step();
    chk("wrap_done", 32'(done_cnt), 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: got no finish expected finish");
    $fatal(1);
  end
endmodule

// File: doc/dtc_share_sched.md
Name: dtc_share_sched

Overview:
- Time-shares one combinational decision-tree classifier (12-bit feature in, 3-bit class out) between NREQ requesters.
- Round-robin arbitration picks a requester and registers its feature vector onto the classifier input.
- The block holds that input for CLS_LAT cycles to cover the multicycle path, then captures the class and returns it with the requester ID over a valid/ready response channel.
- Sits between feature producers and the classifier instance.

Parameters:
- NREQ, 4, number of requesters (2..8).
- IDW, 2, requester ID width; must satisfy 2^IDW >= NREQ.
- CLS_LAT, 2, cycles the classifier input is held before capture (1..15).
- CNTW, 16, width of completed-classification counter.

Ports:
- clk, in, 1: clock, rising edge.
- rst_n, in, 1: asynchronous active-low reset.
- req_valid, in, NREQ: per-requester request valid.
- req_feat, in, NREQ*12: feature vectors; requester i uses bits [12i+11:12i].
- req_ready, out, NREQ: per-requester accept (at most one bit high).
- cls_inp, out, 12: registered feature vector to the classifier.
- cls_outp, in, 3: classifier result.
- rsp_valid, out, 1: response valid.
- rsp_id, out, IDW: index of the requester being answered.
- rsp_class, out, 3: captured class.
- rsp_ready, in, 1: response consumer ready.
- busy, out, 1: high in any state other than IDLE.
- done_cnt, out, CNTW: number of completed responses.

Behaviour:
- Reset (async assert, synchronous deassert handled upstream) drives these values: state=IDLE, rr_ptr=0, cls_inp=0, rsp_valid=0, rsp_id=0, rsp_class=0, done_cnt=0, busy=0, req_ready=0.
- FSM states are IDLE, EVAL, RESP.
- IDLE:
  - Round-robin search starts at rr_ptr and wraps modulo NREQ. The first i with req_valid[i]=1 wins.
  - req_ready[winner]=1 combinationally, only in IDLE. All other req_ready bits are 0. If no requester is valid, all bits are 0.
  - On the accept edge: cls_inp<=req_feat[winner], gnt_id<=winner, wait counter<=CLS_LAT-1, state->EVAL.
- EVAL:
  - cls_inp is held stable. The counter decrements each cycle.
  - When counter==0: rsp_class<=cls_outp, rsp_id<=gnt_id, rsp_valid<=1, state->RESP.
  - Accept-to-rsp_valid latency is exactly CLS_LAT+1 cycles. With CLS_LAT=1 the capture occurs on the first EVAL cycle.
- RESP:
  - rsp_valid, rsp_id and rsp_class stay stable until rsp_ready=1.
  - On rsp_valid&rsp_ready: rsp_valid<=0, done_cnt<=done_cnt+1 (wraps at 2^CNTW), rr_ptr<=(gnt_id+1) mod NREQ, state->IDLE.
  - No new request is accepted in the handshake cycle. The earliest next accept is the following cycle.
- Throughput is one classification per CLS_LAT+2 cycles minimum.
- Fairness: a continuously valid requester is served within NREQ grants.
- Requesters may drop req_valid before being granted; the block does not require request stability.
- The captured feature is immune to req_feat changes after accept.
- rsp_ready while rsp_valid=0 is ignored.
- rr_ptr updates only on response completion, never on accept.
- Reset mid-EVAL or mid-RESP aborts the transaction. The response is lost and no done_cnt increment occurs.
- cls_inp retains its last value in IDLE; it is not cleared.

Test Plan:
- Single request, CLS_LAT=2: req_valid=4'b0001, feat=12'h0A5 -> req_ready[0]=1 for one cycle, cls_inp=12'h0A5; a stubbed classifier returning 3'b110 gives rsp_valid 3 cycles after accept with rsp_id=0, rsp_class=3'b110; done_cnt=1 after the handshake.
- Round-robin, all four requesters held valid, rsp_ready tied 1 -> grant order 0,1,2,3,0; each accept spaced CLS_LAT+2=4 cycles apart.
- Backpressure: rsp_ready=0 for 10 cycles in RESP -> rsp_valid, rsp_id and rsp_class stable; req_ready=0 throughout; busy=1; release gives exactly one done_cnt increment.
- Feature stability: change req_feat[0] to 12'hFFF one cycle after accept -> cls_inp unchanged until the next accept.
- Reset during EVAL: pull rst_n low -> all outputs at reset values immediately (asynchronous); after release, requester 0 is granted first (rr_ptr=0).
- Counter wrap, CNTW=4: complete 17 transactions -> done_cnt=1.
